// File: rtl/ux607_qspi_icb_arb_if.sv
// ICB command/response bundle shared by the QSPI arbiter's requester and slave sides.
interface ux607_qspi_icb_arb_if #(
    parameter int AW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_read;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ux607_qspi_icb_arb.sv
// 2:1 round-robin ICB arbiter in front of the QSPI controller slave port,
// with grant lock on stalled commands and in-order response routing.

module ux607_qspi_icb_arb_chk (
    input logic clk,
    input logic rst,
    input logic s_rsp_valid,
    input logic fifo_empty
);
    // The QSPI slave must never answer when nothing is outstanding.
    rsp_without_cmd_a: assert property (@(posedge clk) disable iff (rst)
        !(s_rsp_valid && fifo_empty));
endmodule

module ux607_qspi_icb_arb #(
    parameter int AW         = 32,
    parameter int OUTS_DEPTH = 2
) (
    input logic                    clk,
    input logic                    rst,
    ux607_qspi_icb_arb_if.slave    m0,
    ux607_qspi_icb_arb_if.slave    m1,
    ux607_qspi_icb_arb_if.master   s
);
    localparam int IW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int PW = IW + 1;
    localparam int FE = 2 ** IW;

    typedef logic [PW-1:0] ptr_t;

    typedef enum logic [0:0] {
        ARB_OPEN   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    arb_state_t state_q, state_d;
    logic       locked_id_q, locked_id_d;
    logic       rr_ptr_q, rr_ptr_d;
    ptr_t       wptr_q, wptr_d;
    ptr_t       rptr_q, rptr_d;
    logic       fifo_q [0:FE-1];
    logic       fifo_d [0:FE-1];
    logic       live_q, live_d;

    ptr_t          occ_s;
    logic          fifo_full_s;
    logic          fifo_empty_s;
    logic          grant_s;
    logic          gnt_valid_s;
    logic          cmd_ready_s;
    logic          cmd_hs_s;
    logic          head_s;
    logic          head_ready_s;
    logic          rsp_ok_s;
    logic          rsp_hs_s;
    logic [AW-1:0] cmd_addr_s;
    logic          cmd_read_s;
    logic [31:0]   cmd_wdata_s;

    assign occ_s        = wptr_q - rptr_q;
    assign fifo_full_s  = (occ_s == PW'(OUTS_DEPTH));
    assign fifo_empty_s = (wptr_q == rptr_q);

    // Grant selection from registered lock/pointer state and current valids.
    always_comb begin
        grant_s = rr_ptr_q;
        if (state_q == ARB_LOCKED) begin
            grant_s = locked_id_q;
        end else if (m0.cmd_valid && !m1.cmd_valid) begin
            grant_s = 1'b0;
        end else if (m1.cmd_valid && !m0.cmd_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = rr_ptr_q;
        end
    end

    // Command mux toward the QSPI slave.
    always_comb begin
        gnt_valid_s = 1'b0;
        cmd_addr_s  = m0.cmd_addr;
        cmd_read_s  = m0.cmd_read;
        cmd_wdata_s = m0.cmd_wdata;
        if (grant_s) begin
            gnt_valid_s = m1.cmd_valid;
            cmd_addr_s  = m1.cmd_addr;
            cmd_read_s  = m1.cmd_read;
            cmd_wdata_s = m1.cmd_wdata;
        end else begin
            gnt_valid_s = m0.cmd_valid;
            cmd_addr_s  = m0.cmd_addr;
            cmd_read_s  = m0.cmd_read;
            cmd_wdata_s = m0.cmd_wdata;
        end
    end

    // live_q holds every handshake output low for the first cycle after reset.
    assign s.cmd_valid  = live_q & ~fifo_full_s & gnt_valid_s;
    assign s.cmd_addr   = cmd_addr_s;
    assign s.cmd_read   = cmd_read_s;
    assign s.cmd_wdata  = cmd_wdata_s;
    assign cmd_ready_s  = live_q & ~fifo_full_s & s.cmd_ready;
    assign m0.cmd_ready = cmd_ready_s & ~grant_s;
    assign m1.cmd_ready = cmd_ready_s & grant_s;
    assign cmd_hs_s     = s.cmd_valid & s.cmd_ready;

    // Response routing follows the requester id at the FIFO head.
    always_comb begin
        head_s       = fifo_q[rptr_q[IW-1:0]];
        head_ready_s = 1'b0;
        if (head_s) begin
            head_ready_s = m1.rsp_ready;
        end else begin
            head_ready_s = m0.rsp_ready;
        end
    end

    assign rsp_ok_s     = live_q & ~fifo_empty_s;
    assign m0.rsp_valid = rsp_ok_s & s.rsp_valid & ~head_s;
    assign m1.rsp_valid = rsp_ok_s & s.rsp_valid & head_s;
    assign s.rsp_ready  = rsp_ok_s & head_ready_s;
    assign m0.rsp_rdata = s.rsp_rdata;
    assign m1.rsp_rdata = s.rsp_rdata;
    assign rsp_hs_s     = s.rsp_valid & s.rsp_ready;

    // Next-state: lock FSM, round-robin pointer and outstanding-id FIFO.
    always_comb begin
        state_d     = state_q;
        locked_id_d = locked_id_q;
        rr_ptr_d    = rr_ptr_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        fifo_d      = fifo_q;
        live_d      = 1'b1;

        case (state_q)
            ARB_OPEN: begin
                if (s.cmd_valid && !s.cmd_ready) begin
                    state_d     = ARB_LOCKED;
                    locked_id_d = grant_s;
                end else begin
                    state_d     = ARB_OPEN;
                end
            end
            ARB_LOCKED: begin
                if (cmd_hs_s) begin
                    state_d = ARB_OPEN;
                end else begin
                    state_d = ARB_LOCKED;
                end
            end
            default: begin
                state_d = ARB_OPEN;
            end
        endcase

        if (cmd_hs_s) begin
            rr_ptr_d                  = ~grant_s;
            wptr_d                    = wptr_q + PW'(1);
            fifo_d[wptr_q[IW-1:0]]    = grant_s;
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        if (rsp_hs_s) begin
            rptr_d = rptr_q + PW'(1);
        end else begin
            rptr_d = rptr_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_OPEN;
            locked_id_q <= 1'b0;
            rr_ptr_q    <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            fifo_q      <= '{default: 1'b0};
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            locked_id_q <= locked_id_d;
            rr_ptr_q    <= rr_ptr_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            fifo_q      <= fifo_d;
            live_q      <= live_d;
        end
    end

    ux607_qspi_icb_arb_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .s_rsp_valid (s.rsp_valid),
        .fifo_empty  (fifo_empty_s)
    );
endmodule

// File: doc/ux607_qspi_icb_arb.md
Name: ux607_qspi_icb_arb

Overview:
- 2:1 ICB arbiter in front of the QSPI flash controller ICB slave port (ux607_qspi_1cs_top).
- Lets two requesters share the single QSPI ICB port: m0 is the XIP instruction-fetch path, m1 is the CPU/peripheral-bus register path.
- Round-robin command arbitration with grant lock while a command is stalled.
- In-order response routing through an outstanding-ID FIFO.

Parameters:
- AW, 32, ICB address width on all ports.
- OUTS_DEPTH, 2, maximum accepted-but-unresponded commands; power of 2, ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_icb_cmd_valid  in  1  requester 0 command valid
- m0_icb_cmd_ready  out  1  requester 0 command ready
- m0_icb_cmd_addr  in  AW  requester 0 address
- m0_icb_cmd_read  in  1  requester 0 read (1) / write (0)
- m0_icb_cmd_wdata  in  32  requester 0 write data
- m0_icb_rsp_valid  out  1  requester 0 response valid
- m0_icb_rsp_ready  in  1  requester 0 response ready
- m0_icb_rsp_rdata  out  32  requester 0 read data
- m1_icb_*  (same eight signals, same directions/widths)  requester 1
- s_icb_cmd_valid  out  1  to QSPI command valid
- s_icb_cmd_ready  in  1  from QSPI command ready
- s_icb_cmd_addr  out  AW  muxed address
- s_icb_cmd_read  out  1  muxed read flag
- s_icb_cmd_wdata  out  32  muxed write data
- s_icb_rsp_valid  in  1  QSPI response valid
- s_icb_rsp_ready  out  1  QSPI response ready
- s_icb_rsp_rdata  in  32  QSPI read data

Behaviour:
- Reset (rst=1 at posedge clk):
  - FIFO empty; rr_ptr=0 (m0 preferred); lock=0.
  - All cmd_ready, rsp_valid and s_icb_cmd_valid read 0 in the first cycle after reset.
- Grant selection (combinational from registered state):
  - If lock=1: grant=locked_id.
  - Else if only one mX_cmd_valid is high: grant=that requester.
  - Else if both are high: grant=rr_ptr.
- Command path (zero latency):
  - s_icb_cmd_valid = fifo_not_full & mGRANT_cmd_valid.
  - addr/read/wdata are muxed from the granted requester.
  - mGRANT_cmd_ready = fifo_not_full & s_icb_cmd_ready; the non-granted cmd_ready = 0.
- Grant lock:
  - If s_icb_cmd_valid=1 and s_icb_cmd_ready=0: lock<=1 and locked_id<=grant.
  - On the cmd handshake: lock<=0.
  - Requesters must not drop valid while stalled (ICB rule).
- Round-robin update: on every cmd handshake, rr_ptr <= ~grant. Single-requester traffic therefore still toggles the pointer.
- Outstanding FIFO:
  - OUTS_DEPTH entries × 1 bit (requester id); wptr/rptr with an extra wrap bit.
  - Push grant on s cmd handshake; pop on s rsp handshake.
  - Full: wptr/rptr equal except wrap bit. Empty: wptr==rptr.
  - When full, new commands are blocked even if a pop occurs in the same cycle. This is intentional: it keeps no combinational path from rsp to cmd_ready.
  - Simultaneous push and pop when not full: both take effect; count unchanged.
- Response path (zero latency, in order):
  - head = FIFO[rptr].
  - mHEAD_rsp_valid = s_icb_rsp_valid & ~empty; the other rsp_valid = 0.
  - s_icb_rsp_ready = ~empty & mHEAD_rsp_ready.
  - rdata is broadcast to both requesters.
  - s_icb_rsp_valid while empty is a protocol error: it is dropped (s_icb_rsp_ready=0) and flagged by a simulation-only assertion.
- Writes also occupy a FIFO slot: the QSPI slave returns one response per command.
- Reset mid-operation: all state is cleared on that edge and in-flight responses are lost. Reset is required to be asserted to the QSPI controller simultaneously.

Test Plan:
- Single m0 read, addr 0x0000_1000, s_cmd_ready=1, rsp 0xDEADBEEF two cycles later -> m0 sees rsp_valid with rdata 0xDEADBEEF; m1_rsp_valid stays 0; FIFO empty afterwards.
- Both valid every cycle, s_cmd_ready=1, responses immediate -> grants alternate m0,m1,m0,m1; each response goes to the matching requester in order.
- m1 presented while s_cmd_ready held 0 for 5 cycles, m0 raises valid in cycle 2 -> grant stays m1 until accepted in cycle 6; m0 is accepted in the next cycle.
- OUTS_DEPTH=2, three back-to-back m0 commands, no responses -> third command sees m0_cmd_ready=0 until the first response handshakes; it is accepted the following cycle, not the same cycle.
- Response backpressure: m1_rsp_ready=0 for 3 cycles with rsp pending at head -> s_icb_rsp_ready=0 for 3 cycles, then data 0x12345678 is delivered once; no duplicate.
- rst=1 asserted with 2 outstanding -> next cycle all ready/valid outputs are 0, FIFO empty, rr_ptr=0; a subsequent simultaneous request is granted to m0.
